// File: rtl/alu_exec_seq_pkg.sv
// rtl/alu_exec_seq_pkg.sv - shared encodings for the ALU execution sequencer
package alu_exec_seq_pkg;

  localparam int NREG = 4;
  localparam int W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SHL  = 3'b110;
  localparam logic [2:0] ALU_SHL2 = 3'b111;

  localparam int OP_LDI_BIT = 3;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational z/n/c/v generation from operands and result
module alu_flag_gen
  import alu_exec_seq_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   s,
  input  logic [W-1:0] r,
  output logic [3:0]   flags
);

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_Z] = (r == '0);
    flags[FLAG_N] = r[W-1];
    case (s)
      ALU_ADD: begin
        flags[FLAG_C] = (({1'b0, a} + {1'b0, b}) > 9'd255);
        flags[FLAG_V] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        // Carry reports borrow for subtraction
        flags[FLAG_C] = (a < b);
        flags[FLAG_V] = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SHL, ALU_SHL2: flags[FLAG_C] = a[W-1];
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - IDLE/EXEC/WB sequencer around an external 8-bit ALU
module alu_exec_seq
  import alu_exec_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [1:0]   in_dst,
  input  logic [1:0]   in_sra,
  input  logic [1:0]   in_srb,
  input  logic [7:0]   in_imm,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [2:0]   alu_s,
  input  logic [7:0]   alu_out,
  output logic         done,
  output logic [3:0]   flags,
  input  logic [1:0]   rd_addr,
  output logic [7:0]   rd_data
);

  state_e         state_q, state_d;
  logic           ldi_q, ldi_d;
  logic [1:0]     dst_q, dst_d;
  logic [W-1:0]   imm_q, imm_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     s_q, s_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   rf_q [NREG];
  logic [W-1:0]   rf_d [NREG];
  logic [3:0]     flags_q, flags_d;
  logic           done_q, done_d;
  logic [3:0]     flag_calc;

  // a/b/s are held through EXEC and WB, so flags can be derived from them at write-back
  alu_flag_gen u_flag_gen (
    .a     (a_q),
    .b     (b_q),
    .s     (s_q),
    .r     (res_q),
    .flags (flag_calc)
  );

  always_comb begin
    state_d = state_q;
    ldi_d   = ldi_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    rf_d    = rf_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ldi_d   = in_op[OP_LDI_BIT];
          dst_d   = in_dst;
          imm_d   = in_imm;
          a_d     = rf_q[in_sra];
          b_d     = rf_q[in_srb];
          s_d     = in_op[2:0];
          state_d = in_op[OP_LDI_BIT] ? ST_WB : ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_out;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_d[dst_q] = ldi_q ? imm_q : res_q;
        if (!ldi_q) flags_d = flag_calc;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ldi_q   <= 1'b0;
      dst_q   <= 2'd0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 3'd0;
      res_q   <= '0;
      flags_q <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ldi_q   <= ldi_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      rf_q    <= rf_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_s    = s_q;
  assign done     = done_q;
  assign flags    = flags_q;
  assign rd_data  = rf_q[rd_addr];

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - scoreboard bench for the ALU execution sequencer
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst, in_sra, in_srb;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_s;
  logic       done;
  logic [3:0] flags;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

  typedef struct {
    logic [1:0] dst;
    logic [7:0] val;
    logic [3:0] fl;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_rf [4];
  logic [3:0] ref_fl;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  alu_exec_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_dst   (in_dst),
    .in_sra   (in_sra),
    .in_srb   (in_srb),
    .in_imm   (in_imm),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_out  (alu_out),
    .done     (done),
    .flags    (flags),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Stand-in for the external combinational ALU
  always_comb begin
    case (alu_s)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = ~alu_a;
      3'b101:  alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a << 1;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] s, input logic [7:0] r);
    int sa, sb_, sr;
    logic c, v;
    sa = int'($signed(a));
    sb_ = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    if (s == 3'b000) begin
      c = (int'(a) + int'(b)) >= 256;
      sr = sa + sb_;
      v = (sr > 127) || (sr < -128);
    end else if (s == 3'b001) begin
      c = int'(a) < int'(b);
      sr = sa - sb_;
      v = (sr > 127) || (sr < -128);
    end else if (s[2:1] == 2'b11) begin
      c = a[7];
    end
    return {r == 8'h00, r[7], c, v};
  endfunction

  function automatic logic [7:0] model_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return 8'((int'(a) + int'(b)) % 256);
      3'b001:  return 8'((int'(a) - int'(b) + 256) % 256);
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return 8'(255 - int'(a));
      3'b101:  return a ^ b;
      default: return 8'((int'(a) * 2) % 256);
    endcase
  endfunction

  task automatic predict(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sra,
                         input logic [1:0] srb, input logic [7:0] imm);
    exp_t e;
    logic [7:0] a, b;
    a = ref_rf[sra];
    b = ref_rf[srb];
    e.dst = dst;
    if (op[3]) begin
      e.val = imm;
      e.fl  = ref_fl;
    end else begin
      e.val = model_alu(a, b, op[2:0]);
      e.fl  = model_flags(a, b, op[2:0], e.val);
    end
    ref_rf[dst] = e.val;
    ref_fl = e.fl;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sra,
                       input logic [1:0] srb, input logic [7:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    in_dst   = dst;
    in_sra   = sra;
    in_srb   = srb;
    in_imm   = imm;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sra,
                       input logic [1:0] srb, input logic [7:0] imm);
    exp_t e;
    logic [7:0] old;
    int cyc;
    bit got;
    old = ref_rf[dst];
    predict(op, dst, sra, srb, imm);
    @(negedge clk);
    rd_addr = dst;
    drive(op, dst, sra, srb, imm);
    check_eq("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else check_eq("prewrite_rd", rd_data, old);
    end
    check_eq("done_seen", got, 1);
    check_eq("latency", cyc, op[3] ? 2 : 3);
    e = sb.pop_front();
    check_eq("flags", flags, e.fl);
    rd_addr = e.dst;
    #1 check_eq("wb_value", rd_data, e.val);
  endtask

  initial begin
    exp_t e;
    int ndone;
    rst_n = 1'b0;
    in_valid = 1'b0;
    drive(4'd0, 2'd0, 2'd0, 2'd0, 8'd0);
    in_valid = 1'b0;
    rd_addr = 2'd0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_fl = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_flags", flags, 0);
    check_eq("rst_alu", {alu_a, alu_b, 5'(alu_s)}, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 check_eq("rst_rf", rd_data, 0);
    end

    issue(4'b1000, 2'd0, 2'd0, 2'd0, 8'h7F);
    issue(4'b1000, 2'd1, 2'd0, 2'd0, 8'h01);
    issue(4'b0000, 2'd2, 2'd0, 2'd1, 8'h00);
    check_eq("add_lit", {rd_data, flags}, {8'h80, 4'b0101});
    issue(4'b1000, 2'd0, 2'd0, 2'd0, 8'h05);
    issue(4'b1000, 2'd1, 2'd0, 2'd0, 8'h07);
    issue(4'b0001, 2'd3, 2'd0, 2'd1, 8'h00);
    check_eq("sub_lit", {rd_data, flags}, {8'hFE, 4'b0110});
    issue(4'b0001, 2'd3, 2'd1, 2'd1, 8'h00);
    check_eq("sub0_lit", {rd_data, flags}, {8'h00, 4'b1000});
    issue(4'b1000, 2'd0, 2'd0, 2'd0, 8'h81);
    issue(4'b0111, 2'd0, 2'd0, 2'd0, 8'h00);
    check_eq("shl_lit", {rd_data, flags}, {8'h02, 4'b0010});
    issue(4'b1000, 2'd1, 2'd0, 2'd0, 8'h55);
    check_eq("ldi_keep_lit", flags, 4'b0010);

    // in_valid held through EXEC/WB with a different instruction
    predict(4'b0000, 2'd3, 2'd0, 2'd1, 8'h00);
    @(negedge clk);
    drive(4'b0000, 2'd3, 2'd0, 2'd1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check_eq("busy_exec", in_ready, 0);
    drive(4'b1000, 2'd3, 2'd0, 2'd0, 8'hEE);
    @(negedge clk);
    check_eq("busy_wb", in_ready, 0);
    check_eq("hold_alu_a", alu_a, 8'h02);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_done", done, 1);
    e = sb.pop_front();
    rd_addr = e.dst;
    #1 check_eq("hold_val", rd_data, e.val);
    check_eq("hold_lit", rd_data, 8'h57);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("hold_extra_done", ndone, 0);

    // reset during EXEC aborts the ADD
    @(negedge clk);
    drive(4'b0000, 2'd2, 2'd0, 2'd1, 8'h00);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_fl = 4'h0;
    @(negedge clk);
    check_eq("abort_ready", in_ready, 1);
    check_eq("abort_flags", flags, 0);
    ndone = done ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 check_eq("abort_rf", rd_data, 0);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);

    issue(4'b1000, 2'd2, 2'd0, 2'd0, 8'hAA);
    issue(4'b0100, 2'd2, 2'd2, 2'd0, 8'h00);
    check_eq("not_lit", {rd_data, flags}, {8'h55, 4'b0000});

    for (int k = 0; k < 24; k++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
